// File: rtl/microcode_state_sequencer.sv
// State register and control-word decoder for the multi-cycle RISC-V CPU.
// Registers the microcode next-state code, stalls on memory wait, absorbs ECALL halts.
module microcode_state_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       next_state,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic [3:0]       current_state,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic [CNT_W-1:0] inst_count
);

  // state          | meaning
  // IF_PC          | fetch at PC, PC+4 into PC when memory answers
  // ID_REG_FETCH   | decode, branch/JAL target into ALUOut
  // EX_LD_SD       | load/store address rs1+imm
  // MEM_READ       | data read, held until mem_ready
  // WB_LD          | MDR to register file
  // MEM_WRITE      | data write, held until mem_ready
  // EX_R / EX_IMM  | ALU R-type / I-type
  // WB_R_I         | ALUOut to register file
  // EX_BRANCH_COND | compare, conditional PC load from ALUOut
  // EX_WB_JAL      | PC <- ALUOut, rd <- PC
  // EX_WB_JALR     | PC <- rs1+imm, rd <- PC
  // EX_ECALL       | environment call, may halt
  // HALT           | absorbing until reset
  typedef enum logic [3:0] {
    IF_PC          = 4'd0,
    ID_REG_FETCH   = 4'd1,
    EX_LD_SD       = 4'd2,
    MEM_READ       = 4'd3,
    WB_LD          = 4'd4,
    MEM_WRITE      = 4'd5,
    EX_R           = 4'd6,
    EX_IMM         = 4'd7,
    WB_R_I         = 4'd8,
    EX_BRANCH_COND = 4'd9,
    EX_WB_JAL      = 4'd10,
    EX_WB_JALR     = 4'd11,
    EX_ECALL       = 4'd12,
    HALT           = 4'd13
  } state_t;

  state_t state, state_nx;
  logic   advance;
  logic   retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IF_PC;
      inst_count <= '0;
    end else begin
      state <= state_nx;
      if (retire) inst_count <= inst_count + CNT_W'(1);
    end
  end

  always_comb begin
    advance  = 1'b1;
    retire   = 1'b0;
    state_nx = state;
    case (state)
      IF_PC, MEM_READ, MEM_WRITE: advance = mem_ready;
      default:                    advance = 1'b1;
    endcase
    if (state != HALT && advance) begin
      case (state)
        WB_LD, MEM_WRITE, WB_R_I, EX_BRANCH_COND,
        EX_WB_JAL, EX_WB_JALR, EX_ECALL: retire = 1'b1;
        default:                         retire = 1'b0;
      endcase
      // Codes above EX_ECALL are not legal targets; HALT is reachable only via ECALL.
      if (state == EX_ECALL && halt_req) state_nx = HALT;
      else if (next_state > 4'd12)       state_nx = IF_PC;
      else                               state_nx = state_t'(next_state);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state)
      IF_PC: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      ID_REG_FETCH: alu_src_b = 2'b10;
      EX_LD_SD: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      WB_LD: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EX_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
      end
      EX_IMM: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      WB_R_I: reg_write = 1'b1;
      EX_BRANCH_COND: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      EX_WB_JAL: begin
        pc_write  = 1'b1;
        pc_source = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
      end
      EX_WB_JALR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
      end
      default: ;
    endcase
  end

  assign current_state = state;
  assign is_halted     = (state == HALT);

endmodule

// File: tb/tb_microcode_state_sequencer.sv
// Scoreboarded bench for microcode_state_sequencer: directed scenarios then random traffic,
// with a 4-bit counter build running in parallel to exercise wraparound.
module tb_microcode_state_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  next_state = 4'd0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;

  logic [3:0]  current_state, cs4;
  logic        pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
  logic        ir_write, reg_write, is_halted;
  logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op;
  logic [31:0] inst_count;
  logic        pw4, pwc4, ps4, iod4, mr4, mw4, ir4, rw4, h4;
  logic [1:0]  wb4, a4, b4, op4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  microcode_state_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset_n), .next_state(next_state), .mem_ready(mem_ready),
    .halt_req(halt_req), .current_state(current_state), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted),
    .inst_count(inst_count)
  );

  microcode_state_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset_n), .next_state(next_state), .mem_ready(mem_ready),
    .halt_req(halt_req), .current_state(cs4), .pc_write(pw4),
    .pc_write_cond(pwc4), .pc_source(ps4), .i_or_d(iod4),
    .mem_read(mr4), .mem_write(mw4), .ir_write(ir4),
    .reg_write(rw4), .wb_sel(wb4), .alu_src_a(a4),
    .alu_src_b(b4), .alu_op(op4), .is_halted(h4),
    .inst_count(cnt4)
  );

  typedef struct packed {
    logic [16:0] word;
    logic [3:0]  state;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [16:0] ctrl_tbl [0:15];
  int          m_state;
  logic [31:0] m_cnt;
  int          n_vec = 0;
  int          n_bad = 0;
  int          retires = 0;

  // word bits: pcw pcwc src iord mrd mwr irw rw wb[2] a[2] b[2] op[2] halted
  initial begin
    for (int i = 0; i < 16; i++) ctrl_tbl[i] = '0;
    ctrl_tbl[0]  = 17'b0_0_0_0_1_0_0_0_00_10_01_00_0;
    ctrl_tbl[1]  = 17'b0_0_0_0_0_0_0_0_00_00_10_00_0;
    ctrl_tbl[2]  = 17'b0_0_0_0_0_0_0_0_00_01_10_00_0;
    ctrl_tbl[3]  = 17'b0_0_0_1_1_0_0_0_00_00_00_00_0;
    ctrl_tbl[4]  = 17'b0_0_0_0_0_0_0_1_01_00_00_00_0;
    ctrl_tbl[5]  = 17'b0_0_0_1_0_1_0_0_00_00_00_00_0;
    ctrl_tbl[6]  = 17'b0_0_0_0_0_0_0_0_00_01_00_10_0;
    ctrl_tbl[7]  = 17'b0_0_0_0_0_0_0_0_00_01_10_11_0;
    ctrl_tbl[8]  = 17'b0_0_0_0_0_0_0_1_00_00_00_00_0;
    ctrl_tbl[9]  = 17'b0_1_1_0_0_0_0_0_00_01_00_01_0;
    ctrl_tbl[10] = 17'b1_0_1_0_0_0_0_1_10_00_00_00_0;
    ctrl_tbl[11] = 17'b1_0_0_0_0_0_0_1_10_01_10_00_0;
    ctrl_tbl[13] = 17'b0_0_0_0_0_0_0_0_00_00_00_00_1;
  end

  function automatic bit is_mem_wait(int s);
    return (s == 0 || s == 3 || s == 5);
  endfunction

  function automatic bit is_retire(int s);
    return (s == 4 || s == 5 || s >= 8 && s <= 12);
  endfunction

  // Apply one cycle of stimulus, push the expected response, then advance the model.
  task automatic cycle(input logic r, input logic [3:0] ns, input logic mr, input logic hr);
    exp_t e;
    @(negedge clk);
    reset_n = r; next_state = ns; mem_ready = mr; halt_req = hr;
    #1;
    if (!r) begin
      m_state = 0;
      m_cnt   = '0;
    end
    e.word = ctrl_tbl[m_state];
    if (m_state == 0 && mr) begin
      e.word[16] = 1'b1;
      e.word[10] = 1'b1;
    end
    e.state = 4'(m_state);
    e.cnt   = m_cnt;
    sb_q.push_back(e);
    if (r && m_state != 13 && !(is_mem_wait(m_state) && !mr)) begin
      if (is_retire(m_state)) begin
        m_cnt = m_cnt + 32'd1;
        retires++;
      end
      if (m_state == 12 && hr) m_state = 13;
      else                     m_state = (ns > 4'd12) ? 0 : int'(ns);
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic [16:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted};
        n_vec++;
        if (act !== e.word || current_state !== e.state || inst_count !== e.cnt ||
            cs4 !== e.state || cnt4 !== e.cnt[3:0] || (mem_read && mem_write) ||
            (pc_write && pc_write_cond)) begin
          n_bad++;
          $display("FAIL vec%0d: state %0d/%0d ctrl %b cnt %0d cnt4 %0d, required state %0d ctrl %b cnt %0d",
                   n_vec, current_state, cs4, act, inst_count, cnt4, e.state, e.word, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int halt_cycles;
    m_state = 0;
    m_cnt   = '0;
    repeat (3) cycle(1'b0, 4'd1, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 4'd1, 1'b0, 1'b0);
    cycle(1'b1, 4'd1, 1'b1, 1'b0);
    cycle(1'b1, 4'd2, 1'b1, 1'b0);
    cycle(1'b1, 4'd3, 1'b1, 1'b0);
    cycle(1'b1, 4'd4, 1'b0, 1'b0);
    cycle(1'b1, 4'd4, 1'b1, 1'b0);
    cycle(1'b1, 4'd0, 1'b1, 1'b0);
    cycle(1'b1, 4'd1, 1'b1, 1'b0);
    cycle(1'b1, 4'd14, 1'b1, 1'b0);
    cycle(1'b1, 4'd1, 1'b1, 1'b0);
    cycle(1'b1, 4'd12, 1'b1, 1'b0);
    cycle(1'b1, 4'd0, 1'b1, 1'b1);
    repeat (20) cycle(1'b1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
    repeat (2) cycle(1'b0, 4'd1, 1'b1, 1'b0);
    halt_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      logic r;
      r = 1'b1;
      if (m_state == 13) begin
        halt_cycles++;
        if ($urandom_range(0, 7) == 0) r = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) r = 1'b0;
      cycle(r, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 2));
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0 || retires < 16 || halt_cycles == 0) begin
      n_bad++;
      $display("FAIL drain: queue %0d retires %0d halted cycles %0d, required queue 0 retires>=16 halted>0",
               sb_q.size(), retires, halt_cycles);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
